inst_fetch_queue: RTL and testbench

//  Decoupling FIFO between the instruction cache and decode.
//  - Each icache data_ok beat pushes 1-2 instructions: rdata_l at pc, and rdata_h at pc+4 when valid.
//  - Presents the two oldest instructions to a dual-issue decode each cycle.
//  - Throttles fetch issue against free space.
//  - Discards stale icache responses after a pipeline redirect (flush).

---
 rtl/inst_fetch_queue.sv | 154 +++++++++++++++
 tb/tb_inst_fetch_queue.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// +--------------------------------------------------------------------------+
// | inst_fetch_queue : icache-to-decode decoupling FIFO, dual-issue output,  |
// |                    fetch throttling and stale-response discard on flush. |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module inst_fetch_queue #(
   parameter int DEPTH   = 8,
   parameter int PTR_W   = 3,
   parameter int MAX_OUT = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        flush,
   input  logic        req_fire,
   output logic        fetch_allow,
   input  logic        in_valid,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_inst0,
   input  logic [31:0] in_inst1,
   input  logic        in_inst1_ok,
   output logic        out0_valid,
   output logic [31:0] out0_pc,
   output logic [31:0] out0_inst,
   output logic        out1_valid,
   output logic [31:0] out1_pc,
   output logic [31:0] out1_inst,
   input  logic [1:0]  pop_cnt,
   output logic        overflow
);

   localparam int c_CNT_W  = PTR_W + 1;
   localparam int c_OUT_W  = $clog2(MAX_OUT + 2);
   localparam int c_DROP_W = 4;
   localparam int c_AW     = c_CNT_W + c_OUT_W + 2;

   logic [31:0]         r_pc_mem   [DEPTH];
   logic [31:0]         r_inst_mem [DEPTH];
   logic [PTR_W-1:0]    r_head;
   logic [PTR_W-1:0]    r_tail;
   logic [c_CNT_W-1:0]  r_count;
   logic [c_OUT_W-1:0]  r_outstanding;
   logic [c_DROP_W-1:0] r_drop_cnt;
   logic                r_overflow;

   logic [PTR_W-1:0]    w_head1;
   logic [PTR_W-1:0]    w_tail1;
   logic [c_CNT_W-1:0]  w_pop_req;
   logic [c_CNT_W-1:0]  w_eff_pop;
   logic [c_CNT_W-1:0]  w_free;
   logic [c_CNT_W-1:0]  w_n;
   logic [c_CNT_W-1:0]  w_n_wr;
   logic [c_CNT_W-1:0]  w_count_next;
   logic                w_push;
   logic                w_wr0;
   logic                w_wr1;
   logic                w_ovf;
   logic                w_live_ack;
   logic [c_OUT_W-1:0]  w_out_inc;
   logic [c_OUT_W-1:0]  w_out_dec;
   logic [c_OUT_W-1:0]  w_out_next;
   logic [c_DROP_W-1:0] w_drop_sum;
   logic [c_DROP_W-1:0] w_drop_flush;
   logic [c_AW-1:0]     w_space;
   logic [c_AW-1:0]     w_need;

   always_comb begin
      w_head1   = r_head + PTR_W'(1);
      w_tail1   = r_tail + PTR_W'(1);
      w_pop_req = (pop_cnt == 2'd3) ? c_CNT_W'(2) : c_CNT_W'(pop_cnt);
      w_eff_pop = (w_pop_req > r_count) ? r_count : w_pop_req;
      // Free space is judged before this cycle's pop.
      w_free    = c_CNT_W'(DEPTH) - r_count;
      w_push    = in_valid & (r_drop_cnt == '0) & ~flush;
      w_n       = in_inst1_ok ? c_CNT_W'(2) : c_CNT_W'(1);
      w_wr0     = w_push & (w_free >= c_CNT_W'(1));
      w_wr1     = w_push & in_inst1_ok & (w_free >= c_CNT_W'(2));
      w_n_wr    = c_CNT_W'(w_wr0) + c_CNT_W'(w_wr1);
      w_ovf     = w_push & (w_n > w_free);
      w_count_next = flush ? '0 : (r_count + w_n_wr - w_eff_pop);

      // Beats arriving while stale responses remain belong to the stale set.
      w_live_ack = in_valid & (r_drop_cnt == '0);
      w_out_inc  = r_outstanding + c_OUT_W'(req_fire);
      w_out_dec  = (w_live_ack && (w_out_inc != '0)) ? (w_out_inc - c_OUT_W'(1)) : w_out_inc;
      if (flush) begin
         w_out_next = '0;
      end else if (w_out_dec > c_OUT_W'(MAX_OUT)) begin
         w_out_next = c_OUT_W'(MAX_OUT);
      end else begin
         w_out_next = w_out_dec;
      end

      w_drop_sum   = r_drop_cnt + c_DROP_W'(r_outstanding) + c_DROP_W'(req_fire);
      w_drop_flush = (in_valid && (w_drop_sum != '0)) ? (w_drop_sum - c_DROP_W'(1)) : w_drop_sum;

      // Reserve two slots for each in-flight request plus the next one.
      w_space     = c_AW'(DEPTH) - c_AW'(w_count_next);
      w_need      = (c_AW'(w_out_next) + c_AW'(1)) << 1;
      fetch_allow = (w_out_inc < c_OUT_W'(MAX_OUT)) && (w_space >= w_need);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_head        <= '0;
         r_tail        <= '0;
         r_count       <= '0;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
         r_overflow    <= 1'b0;
      end else begin
         if (flush) begin
            r_head        <= r_tail;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= w_drop_flush;
         end else begin
            r_head        <= r_head + w_eff_pop[PTR_W-1:0];
            r_tail        <= r_tail + w_n_wr[PTR_W-1:0];
            r_count       <= w_count_next;
            r_outstanding <= w_out_next;
            if (in_valid && (r_drop_cnt != '0)) begin
               r_drop_cnt <= r_drop_cnt - c_DROP_W'(1);
            end
         end
         if (w_ovf) begin
            r_overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr0) begin
         r_pc_mem[r_tail]   <= in_pc;
         r_inst_mem[r_tail] <= in_inst0;
      end
      if (w_wr1) begin
         r_pc_mem[w_tail1]   <= in_pc + 32'd4;
         r_inst_mem[w_tail1] <= in_inst1;
      end
   end

   assign out0_valid = (r_count != '0);
   assign out1_valid = (r_count >= c_CNT_W'(2));
   assign out0_pc    = r_pc_mem[r_head];
   assign out0_inst  = r_inst_mem[r_head];
   assign out1_pc    = r_pc_mem[w_head1];
   assign out1_inst  = r_inst_mem[w_head1];
   assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
// Randomized scoreboard bench for inst_fetch_queue: an in-order icache model
// feeds expected entries to a queue model that a separate monitor checks.
`default_nettype none

module tb_inst_fetch_queue;
   localparam int DEPTH   = 8;
   localparam int MAX_OUT = 2;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        flush = 1'b0;
   logic        req_fire = 1'b0;
   logic        fetch_allow;
   logic        in_valid = 1'b0;
   logic [31:0] in_pc = '0;
   logic [31:0] in_inst0 = '0;
   logic [31:0] in_inst1 = '0;
   logic        in_inst1_ok = 1'b0;
   logic        out0_valid, out1_valid, overflow;
   logic [31:0] out0_pc, out0_inst, out1_pc, out1_inst;
   logic [1:0]  pop_cnt = '0;

   inst_fetch_queue #(.DEPTH(DEPTH), .PTR_W(3), .MAX_OUT(MAX_OUT)) dut (
      .clk(clk), .resetn(resetn), .flush(flush), .req_fire(req_fire),
      .fetch_allow(fetch_allow), .in_valid(in_valid), .in_pc(in_pc),
      .in_inst0(in_inst0), .in_inst1(in_inst1), .in_inst1_ok(in_inst1_ok),
      .out0_valid(out0_valid), .out0_pc(out0_pc), .out0_inst(out0_inst),
      .out1_valid(out1_valid), .out1_pc(out1_pc), .out1_inst(out1_inst),
      .pop_cnt(pop_cnt), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t sb[$];      // expected queue contents, oldest first
   ent_t stage[$];   // entries delivered by the icache this cycle
   bit   pend[$];    // in-flight icache requests, 1 = stale
   bit   m_ovf = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   m_req, m_eff, m_free;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int live_cnt();
      int c = 0;
      foreach (pend[i]) if (!pend[i]) c++;
      return c;
   endfunction

   // Monitor: checks presented outputs, then retires what decode consumed.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         chk("out0_valid", 64'(out0_valid), 64'(sb.size() >= 1));
         chk("out1_valid", 64'(out1_valid), 64'(sb.size() >= 2));
         chk("overflow", 64'(overflow), 64'(m_ovf));
         if (sb.size() >= 1) chk("out0_entry", {out0_pc, out0_inst}, sb[0]);
         if (sb.size() >= 2) chk("out1_entry", {out1_pc, out1_inst}, sb[1]);
         #5;
         if (!resetn) begin
            sb.delete();
            stage.delete();
            m_ovf = 1'b0;
         end else if (flush) begin
            sb.delete();
            stage.delete();
         end else begin
            m_req  = (pop_cnt == 2'd3) ? 2 : int'(pop_cnt);
            m_eff  = (m_req < sb.size()) ? m_req : sb.size();
            m_free = DEPTH - sb.size();
            for (int k = 0; k < m_eff; k++) begin
               if (k == 0) chk("pop0", {out0_pc, out0_inst}, sb[0]);
               else        chk("pop1", {out1_pc, out1_inst}, sb[0]);
               void'(sb.pop_front());
            end
            if (stage.size() > m_free) m_ovf = 1'b1;
            foreach (stage[i]) if (i < m_free) sb.push_back(stage[i]);
            stage.delete();
         end
      end
   end

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
         resetn = 1'b0; flush = 1'b0; req_fire = 1'b0; in_valid = 1'b0;
         in_inst1_ok = 1'b0; pop_cnt = '0;
         pend.delete();
      end
   endtask

   // One cycle of stimulus; the icache answers requests strictly in order.
   task automatic step(input bit f, input bit want_req, input bit iv, input bit ok,
                       input logic [31:0] pc, input logic [1:0] pop, input bit force_req);
      int  sz, out_b, eff, n_wr, sz_next, live_next, preq;
      bit  stale_beat, allow0, allow1;
      @(posedge clk);
      #2;
      if (pend.size() == 0) iv = 1'b0;
      sz         = sb.size();
      out_b      = live_cnt();
      live_next  = out_b;
      stale_beat = 1'b0;
      resetn = 1'b1; flush = f; in_valid = iv; in_inst1_ok = ok; in_pc = pc;
      in_inst0 = $urandom; in_inst1 = $urandom; pop_cnt = pop; req_fire = 1'b0;
      if (iv) begin
         stale_beat = pend.pop_front();
         if (!stale_beat) live_next--;
      end
      preq = (pop == 2'd3) ? 2 : int'(pop);
      eff  = f ? 0 : ((preq < sz) ? preq : sz);
      n_wr = 0;
      if (iv && !stale_beat && !f) begin
         stage.push_back({pc, in_inst0});
         if (ok) stage.push_back({pc + 32'd4, in_inst1});
         n_wr = ok ? 2 : 1;
         if (n_wr > DEPTH - sz) n_wr = DEPTH - sz;
      end
      sz_next = f ? 0 : (sz + n_wr - eff);
      if (f) begin
         foreach (pend[i]) pend[i] = 1'b1;
         live_next = 0;
      end
      allow0 = (out_b < MAX_OUT) && (DEPTH - sz_next >= 2 * (live_next + 1));
      #1;
      chk("fetch_allow_idle", 64'(fetch_allow), 64'(allow0));
      if ((want_req && allow0 && pend.size() < 4) || force_req) begin
         req_fire = 1'b1;
         pend.push_back(f);
         if (!f) live_next++;
         allow1 = (out_b + 1 < MAX_OUT) && (DEPTH - sz_next >= 2 * (live_next + 1));
         #1;
         chk("fetch_allow_req", 64'(fetch_allow), 64'(allow1));
      end
   endtask

   initial begin
      #2_000_000;
      n_bad++;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      do_reset(2);
      // Dual push then display.
      step(0, 1, 0, 0, 32'h0, 0, 0);
      step(0, 0, 1, 1, 32'h1c000000, 0, 0);
      step(0, 0, 0, 0, 32'h0, 0, 0);
      // Single push then single pop.
      do_reset(1);
      step(0, 1, 0, 0, 32'h0, 0, 0);
      step(0, 0, 1, 0, 32'h1c00001c, 0, 0);
      step(0, 0, 0, 0, 32'h0, 1, 0);
      step(0, 0, 0, 0, 32'h0, 0, 0);
      // Fill to full with legal fetch, then force one more beat: overflow.
      do_reset(1);
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 0, 0, 32'h0, 0, 0);
         step(0, 0, 1, 1, 32'h1c000000 + 32'(i * 8), 0, 0);
      end
      step(0, 0, 0, 0, 32'h0, 0, 1);
      step(0, 0, 1, 1, 32'h1c000040, 2, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 32'h0, 2, 0);
      // Two requests, flush, two stale beats, then a live beat.
      do_reset(1);
      step(0, 1, 0, 0, 32'h0, 0, 0);
      step(0, 1, 0, 0, 32'h0, 0, 0);
      step(1, 0, 0, 0, 32'h0, 0, 0);
      step(0, 0, 1, 1, 32'h1c000080, 0, 0);
      step(0, 1, 1, 1, 32'h1c000088, 0, 0);
      step(0, 0, 1, 0, 32'h1c000100, 0, 0);
      step(0, 0, 0, 0, 32'h0, 1, 0);
      // Flush with same-cycle beat, request and pop at count=4, one outstanding.
      do_reset(1);
      step(0, 1, 0, 0, 32'h0, 0, 0);
      step(0, 1, 1, 1, 32'h1c000200, 0, 0);
      step(0, 1, 1, 1, 32'h1c000208, 0, 0);
      step(1, 1, 1, 1, 32'h1c000210, 2, 0);
      step(0, 0, 1, 1, 32'h1c000218, 0, 0);
      step(0, 0, 0, 0, 32'h0, 0, 0);
      // Walk head around the ring, then a dual push that wraps.
      do_reset(1);
      step(0, 1, 0, 0, 32'h0, 0, 0);
      for (int i = 0; i < 7; i++) step(0, 1, 1, 0, 32'h1c000300 + 32'(i * 4), 1, 0);
      step(0, 0, 1, 1, 32'h1c000400, 1, 0);
      step(0, 0, 0, 0, 32'h0, 2, 0);
      step(0, 0, 0, 0, 32'h0, 2, 0);
      // Random traffic with occasional flushes and resets.
      for (int i = 0; i < 3000; i++) begin
         if (i % 700 == 699) do_reset(1);
         step(($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
              $urandom & 32'hffff_fffc, 2'($urandom), 0);
      end
      step(0, 0, 0, 0, 32'h0, 0, 0);
      step(0, 0, 0, 0, 32'h0, 0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
